// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button conditioner: polarity, 2-flop sync, stability debounce, strobes
//
// Purpose:
//   Cleans up raw board push-buttons for the SoC GPIO inputs. Each channel is
//   inverted if ACTIVE_LOW, synchronised into i_clk with two flops, and only
//   accepted as a new level after DEBOUNCE_CYCLES consecutive samples that
//   differ from the current debounced level. Press/release strobes are one
//   cycle wide and registered alongside the level.
//
// Optional feature (macro BTN_DEBOUNCE_IRQ_EN):
//   Defined   - sticky per-channel press events (o_evt) with per-channel clear
//               (set wins over clear) and a registered OR interrupt (o_irq).
//   Undefined - o_evt and o_irq are constant 0 and i_evt_clr is ignored.
//
// Ports:
//   i_clk      in   1      system clock
//   i_rst_n    in   1      asynchronous active-low reset
//   i_btn      in   N_BTN  raw asynchronous button pins
//   o_btn      out  N_BTN  debounced level, 1 = pressed
//   o_press    out  N_BTN  one-cycle strobe on o_btn 0->1
//   o_release  out  N_BTN  one-cycle strobe on o_btn 1->0
//   i_evt_clr  in   N_BTN  per-channel sticky-event clear
//   o_evt      out  N_BTN  sticky press events
//   o_irq      out  1      registered OR of o_evt

module btn_debounce #(
  parameter int N_BTN           = 6,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  input  logic [N_BTN-1:0] i_evt_clr,
  output logic [N_BTN-1:0] o_evt,
  output logic             o_irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] b;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] btn_next;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;

  // Polarity is fixed before the synchroniser so that its reset value of 0
  // always means "not pressed".
  assign b = i_btn ^ {N_BTN{ACTIVE_LOW != 0}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= b;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the window, and acceptance also clears it,
    // so the count never reaches past CNT_MAX.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt <= '0;
      end else if (s2[g] == btn_q[g] || cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign btn_next[g] = (s2[g] != btn_q[g] && cnt == CNT_MAX) ? s2[g] : btn_q[g];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      btn_q     <= btn_next;
      press_q   <= btn_next & ~btn_q;
      release_q <= ~btn_next & btn_q;
    end
  end

  assign o_btn     = btn_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef BTN_DEBOUNCE_IRQ_EN
  logic [N_BTN-1:0] evt_q;
  logic             irq_q;

  // A press in the same cycle as a clear keeps the event: firmware must not
  // lose a press that lands while it is acknowledging the previous one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= (evt_q & ~i_evt_clr) | press_q;
      irq_q <= |evt_q;
    end
  end

  assign o_evt = evt_q;
  assign o_irq = irq_q;
`else
  logic unused_evt_clr;

  assign unused_evt_clr = ^i_evt_clr;
  assign o_evt          = '0;
  assign o_irq          = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce (active-high and active-low instances)

module tb_btn_debounce;

  localparam int N  = 6;
  localparam int DC = 16;

  typedef struct packed {
    logic [N-1:0] btn;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] evt;
    logic         irq;
  } out_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_a;
  logic [N-1:0] btn_b;
  logic [N-1:0] evt_clr;

  logic [N-1:0] a_btn, a_press, a_rel, a_evt;
  logic         a_irq;
  logic [N-1:0] b_btn, b_press, b_rel, b_evt;
  logic         b_irq;

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(0)) dut_hi (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_a),
    .o_btn(a_btn), .o_press(a_press), .o_release(a_rel),
    .i_evt_clr(evt_clr), .o_evt(a_evt), .o_irq(a_irq)
  );

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1)) dut_lo (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_b),
    .o_btn(b_btn), .o_press(b_press), .o_release(b_rel),
    .i_evt_clr(evt_clr), .o_evt(b_evt), .o_irq(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  out_t q0[$];
  out_t q1[$];

  // Reference model: a channel's level flips once the last DC synchronised
  // samples (the inputs seen 2..DC+1 edges ago) all disagree with it.
  logic [N-1:0] hist [0:1][0:DC+1];
  logic [N-1:0] m_btn   [0:1];
  logic [N-1:0] m_press [0:1];
  logic [N-1:0] m_rel   [0:1];
  logic [N-1:0] m_evt   [0:1];
  logic         m_irq   [0:1];

  task automatic model_step(input int d, input logic rst, input logic [N-1:0] raw,
                            input logic [N-1:0] clr);
    logic [N-1:0] corr;
    logic [N-1:0] all_diff;
    logic [N-1:0] nb;
    logic [N-1:0] nevt;
    logic         nirq;
    corr = (d == 1) ? ~raw : raw;
    if (!rst) begin
      for (int j = 0; j < DC + 2; j++) hist[d][j] = '0;
      m_btn[d] = '0; m_press[d] = '0; m_rel[d] = '0; m_evt[d] = '0; m_irq[d] = 1'b0;
    end else begin
      for (int j = DC + 1; j > 0; j--) hist[d][j] = hist[d][j-1];
      hist[d][0] = corr;
      all_diff = '1;
      for (int j = 2; j < DC + 2; j++) all_diff = all_diff & (hist[d][j] ^ m_btn[d]);
      nb = m_btn[d] ^ all_diff;
`ifdef BTN_DEBOUNCE_IRQ_EN
      nevt = (m_evt[d] & ~clr) | m_press[d];
      nirq = |m_evt[d];
`else
      nevt = '0;
      nirq = 1'b0;
`endif
      m_press[d] = nb & ~m_btn[d];
      m_rel[d]   = ~nb & m_btn[d];
      m_btn[d]   = nb;
      m_evt[d]   = nevt;
      m_irq[d]   = nirq;
    end
  endtask

  logic [N-1:0] sa, sb;

  task automatic cyc(input logic rst, input logic [N-1:0] clr);
    out_t e;
    @(negedge clk);
    rst_n   = rst;
    btn_a   = sa;
    btn_b   = sb;
    evt_clr = clr;
    model_step(0, rst, sa, clr);
    model_step(1, rst, sb, clr);
    e.btn = m_btn[0]; e.press = m_press[0]; e.rel = m_rel[0]; e.evt = m_evt[0]; e.irq = m_irq[0];
    q0.push_back(e);
    e.btn = m_btn[1]; e.press = m_press[1]; e.rel = m_rel[1]; e.evt = m_evt[1]; e.irq = m_irq[1];
    q1.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, '0);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock edge, checked 1 time unit after it.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        e = q0.pop_front();
        chk("hi.btn",   a_btn,   e.btn);
        chk("hi.press", a_press, e.press);
        chk("hi.rel",   a_rel,   e.rel);
        chk("hi.evt",   a_evt,   e.evt);
        chk("hi.irq",   {5'b0, a_irq}, {5'b0, e.irq});
        e = q1.pop_front();
        chk("lo.btn",   b_btn,   e.btn);
        chk("lo.press", b_press, e.press);
        chk("lo.rel",   b_rel,   e.rel);
        chk("lo.evt",   b_evt,   e.evt);
        chk("lo.irq",   {5'b0, b_irq}, {5'b0, e.irq});
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    sa      = 6'h3F;
    sb      = 6'h00;
    btn_a   = sa;
    btn_b   = sb;
    evt_clr = '0;

    // All buttons held through reset, then reported as fresh presses.
    for (int i = 0; i < 5; i++) cyc(1'b0, '0);
    run(25);

    // Clean press and release on channel 0.
    sa = 6'h00; sb = 6'h3F; run(25);
    sa = 6'h01; run(25);
    sa = 6'h00; run(25);

    // Bounce on channel 2: 10 high, 3 low, 20 high.
    sa = 6'h04; run(10);
    sa = 6'h00; run(3);
    sa = 6'h04; run(20);
    sa = 6'h00; run(25);

    // Active-low instance: channel 5 pin pulled low.
    sb = 6'h1F; run(25);
    sb = 6'h3F; run(25);

    // Channel 1 held, reset pulsed mid-count, press re-reported after release.
    sa = 6'h02; run(9);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0);
    run(25);
    sa = 6'h00; run(25);

    // Sticky events on channel 3: set, clear alone, clear coinciding with a press.
    sa = 6'h08; run(25);
    cyc(1'b1, 6'h08); run(3);
    sa = 6'h00; run(25);
    sa = 6'h08;
    for (int i = 0; i < 25; i++) cyc(1'b1, m_press[0] & 6'h08);
    run(3);
    cyc(1'b1, 6'h08); run(3);

    // Randomised bouncing on both instances with occasional clears and resets.
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] clr;
      logic         rst;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 11) == 0) sa[c] = ~sa[c];
        if ($urandom_range(0, 11) == 0) sb[c] = ~sb[c];
      end
      clr = N'($urandom) & N'($urandom) & N'($urandom);
      rst = ($urandom_range(0, 299) != 0);
      cyc(rst, clr);
    end
    run(4);

    @(posedge clk);
    #2;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
